// File: rtl/tmr_irq_arbiter_pkg.sv
// Shared constants for the timer interrupt arbiter: source kinds, FSM states
// and the channel/kind to flat source index mapping.
package tmr_pkg;
  localparam int SRC_CMIA = 0;
  localparam int SRC_CMIB = 1;
  localparam int SRC_OVI  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int src_idx(input int ch, input int kind);
    return 3 * ch + kind;
  endfunction
endpackage

// File: rtl/tmr_irq_arbiter_prio_pick.sv
// Find-first-set over N request bits, searching upward from base and wrapping.
module tmr_prio_pick #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] base_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);
  int j;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(base_i) + i) % N;
      if (!vld_o && req_i[j]) begin
        vld_o = 1'b1;
        idx_o = W'(j);
      end
    end
  end
endmodule

// File: rtl/tmr_irq_arbiter.sv
// Timer interrupt collector: edge-latched pending flags, enable mask, fixed or
// round-robin arbitration and a req/ack handshake towards the CPU.
module tmr_irq_arbiter
  import tmr_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int VEC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      cmia,
  input  logic [NUM_CH-1:0]      cmib,
  input  logic [NUM_CH-1:0]      ovi,
  input  logic                   ier_we,
  input  logic [3*NUM_CH-1:0]    ier_wdata,
  input  logic                   rr_mode,
  input  logic [3*NUM_CH-1:0]    pend_clr,
  input  logic                   irq_ack,
  output logic                   irq,
  output logic [VEC_WIDTH-1:0]   irq_vec,
  output logic [3*NUM_CH-1:0]    pending,
  output logic [3*NUM_CH-1:0]    ier
);
  localparam int NSRC = 3 * NUM_CH;

  logic [NSRC-1:0]      src, hist_q, rise, pend_q, pend_d, pend_nack;
  logic [NSRC-1:0]      ier_q, ier_d, cand, ack_clr;
  logic [VEC_WIDTH-1:0] irq_vec_q, last_q, base, pick_idx;
  logic                 pick_vld, irq_q, ack_now, withdraw;
  state_e               st_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_src
    assign src[src_idx(n, SRC_CMIA)] = cmia[n];
    assign src[src_idx(n, SRC_CMIB)] = cmib[n];
    assign src[src_idx(n, SRC_OVI)]  = ovi[n];
  end

  assign rise    = src & ~hist_q;
  assign cand    = pend_q & ier_q;
  assign ack_now = (st_q == ST_REQ) && irq_ack;

  always_comb begin
    ack_clr = '0;
    if (ack_now) ack_clr[irq_vec_q] = 1'b1;
  end

  // A rise always wins over any clear in the same cycle.
  assign pend_nack = rise | (pend_q & ~pend_clr);
  assign pend_d    = rise | (pend_q & ~(pend_clr | ack_clr));
  assign ier_d     = ier_we ? ier_wdata : ier_q;

  // Drop the request on the same edge the granted bit stops being a candidate.
  assign withdraw  = ~(pend_nack[irq_vec_q] & ier_d[irq_vec_q]);

  assign base = !rr_mode                         ? '0 :
                (last_q == VEC_WIDTH'(NSRC - 1)) ? '0 : last_q + 1'b1;

  tmr_prio_pick #(.N(NSRC), .W(VEC_WIDTH)) u_pick (
    .req_i  (cand),
    .base_i (base),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      pend_q    <= '0;
      ier_q     <= '0;
      irq_q     <= 1'b0;
      irq_vec_q <= '0;
      last_q    <= '0;
      st_q      <= ST_IDLE;
    end else begin
      hist_q <= src;
      pend_q <= pend_d;
      ier_q  <= ier_d;
      case (st_q)
        ST_IDLE: if (pick_vld) begin
          irq_vec_q <= pick_idx;
          irq_q     <= 1'b1;
          st_q      <= ST_REQ;
        end
        ST_REQ: if (ack_now) begin
          last_q <= irq_vec_q;
          irq_q  <= 1'b0;
          st_q   <= ST_GAP;
        end else if (withdraw) begin
          irq_q <= 1'b0;
          st_q  <= ST_GAP;
        end
        ST_GAP:  st_q <= ST_IDLE;
        default: begin
          irq_q <= 1'b0;
          st_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;
  assign pending = pend_q;
  assign ier     = ier_q;
endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Directed bench for tmr_irq_arbiter: a per-cycle vector table plus hand
// sequences for set/clear races, withdrawal, round-robin order and reset.
module tb_tmr_irq_arbiter;
  logic        clk, rst_n;
  logic [3:0]  cmia, cmib, ovi;
  logic        ier_we, rr_mode, irq_ack;
  logic [11:0] ier_wdata, pend_clr;
  logic        irq;
  logic [3:0]  irq_vec;
  logic [11:0] pending, ier;

  int n_chk  = 0;
  int n_fail = 0;

  tmr_irq_arbiter #(.NUM_CH(4), .VEC_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmia(cmia), .cmib(cmib), .ovi(ovi),
    .ier_we(ier_we), .ier_wdata(ier_wdata), .rr_mode(rr_mode),
    .pend_clr(pend_clr), .irq_ack(irq_ack), .irq(irq), .irq_vec(irq_vec),
    .pending(pending), .ier(ier)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] src;
    logic        we;
    logic [11:0] wdata;
    logic [11:0] clr;
    logic        ack;
    logic        exp_irq;
    logic [3:0]  exp_vec;
    logic [11:0] exp_pend;
    logic [11:0] exp_ier;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic [11:0] src, logic we, logic [11:0] wdata,
                              logic [11:0] clr, logic ack, logic e_irq,
                              logic [3:0] e_vec, logic [11:0] e_pend,
                              logic [11:0] e_ier);
    vec_t v;
    v.src = src; v.we = we; v.wdata = wdata; v.clr = clr; v.ack = ack;
    v.exp_irq = e_irq; v.exp_vec = e_vec; v.exp_pend = e_pend; v.exp_ier = e_ier;
    return v;
  endfunction

  task automatic set_src(input logic [11:0] s);
    for (int n = 0; n < 4; n++) begin
      cmia[n] = s[3*n];
      cmib[n] = s[3*n+1];
      ovi[n]  = s[3*n+2];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for a request, check its vector, ack it, then pulse rep for one cycle.
  task automatic grant_cycle(input logic [3:0] exp_vec, input logic [11:0] rep);
    for (int i = 0; i < 8; i++) begin
      if (irq) break;
      tick();
    end
    chk("grant irq", {31'd0, irq}, 32'd1);
    chk("grant vec", {28'd0, irq_vec}, {28'd0, exp_vec});
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack drops irq", {31'd0, irq}, 32'd0);
    set_src(rep);
    tick();
    set_src('0);
  endtask

  initial begin
    tbl[0]  = mk(12'h000, 1, 12'hFFF, 0, 0, 0, 0, 12'h000, 12'hFFF);
    tbl[1]  = mk(12'h044, 0, 0,       0, 0, 0, 0, 12'h044, 12'hFFF);
    tbl[2]  = mk(12'h000, 0, 0,       0, 0, 1, 2, 12'h044, 12'hFFF);
    tbl[3]  = mk(12'h000, 0, 0,       0, 0, 1, 2, 12'h044, 12'hFFF);
    tbl[4]  = mk(12'h000, 0, 0,       0, 1, 0, 2, 12'h040, 12'hFFF);
    tbl[5]  = mk(12'h000, 0, 0,       0, 0, 0, 2, 12'h040, 12'hFFF);
    tbl[6]  = mk(12'h000, 0, 0,       0, 0, 1, 6, 12'h040, 12'hFFF);
    tbl[7]  = mk(12'h000, 0, 0,       0, 1, 0, 6, 12'h000, 12'hFFF);
    tbl[8]  = mk(12'h000, 0, 0,       0, 0, 0, 6, 12'h000, 12'hFFF);
    tbl[9]  = mk(12'h000, 1, 12'h000, 0, 0, 0, 6, 12'h000, 12'h000);
    tbl[10] = mk(12'h010, 0, 0,       0, 0, 0, 6, 12'h010, 12'h000);
    tbl[11] = mk(12'h000, 0, 0,       0, 0, 0, 6, 12'h010, 12'h000);
    tbl[12] = mk(12'h000, 0, 0,       0, 1, 0, 6, 12'h010, 12'h000);
    tbl[13] = mk(12'h000, 1, 12'h010, 0, 0, 0, 6, 12'h010, 12'h010);
    tbl[14] = mk(12'h000, 0, 0,       0, 0, 1, 4, 12'h010, 12'h010);
    tbl[15] = mk(12'h000, 0, 0,       0, 1, 0, 4, 12'h000, 12'h010);
    tbl[16] = mk(12'h000, 0, 0,       0, 0, 0, 4, 12'h000, 12'h010);
    tbl[17] = mk(12'h000, 1, 12'hFFF, 0, 0, 0, 4, 12'h000, 12'hFFF);

    rst_n = 1'b0; set_src('0); ier_we = 0; ier_wdata = '0;
    rr_mode = 0; pend_clr = '0; irq_ack = 0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset irq",  {31'd0, irq}, 32'd0);
    chk("reset vec",  {28'd0, irq_vec}, 32'd0);
    chk("reset pend", {20'd0, pending}, 32'd0);
    chk("reset ier",  {20'd0, ier}, 32'd0);

    // Fixed priority, ack/GAP spacing, masking, ack outside REQ.
    for (int r = 0; r < 18; r++) begin
      set_src(tbl[r].src);
      ier_we = tbl[r].we; ier_wdata = tbl[r].wdata;
      pend_clr = tbl[r].clr; irq_ack = tbl[r].ack;
      tick();
      chk($sformatf("row%0d irq", r),  {31'd0, irq}, {31'd0, tbl[r].exp_irq});
      chk($sformatf("row%0d vec", r),  {28'd0, irq_vec}, {28'd0, tbl[r].exp_vec});
      chk($sformatf("row%0d pend", r), {20'd0, pending}, {20'd0, tbl[r].exp_pend});
      chk($sformatf("row%0d ier", r),  {20'd0, ier}, {20'd0, tbl[r].exp_ier});
    end
    set_src('0); ier_we = 0; pend_clr = '0; irq_ack = 0;

    // Set beats clear; a held-high source latches only once.
    set_src(12'h008); pend_clr = 12'h008;
    tick();
    pend_clr = '0;
    chk("setclr pend", {20'd0, pending}, 32'h008);
    tick();
    chk("held irq", {31'd0, irq}, 32'd1);
    chk("held vec", {28'd0, irq_vec}, 32'd3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("held ack irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("held no regrant", {31'd0, irq}, 32'd0);
      chk("held no repend", {20'd0, pending}, 32'd0);
    end
    set_src('0);
    tick();

    // Withdrawal by pend_clr while in REQ.
    set_src(12'h080);
    tick();
    set_src('0);
    chk("wd pend", {20'd0, pending}, 32'h080);
    tick();
    chk("wd irq", {31'd0, irq}, 32'd1);
    chk("wd vec", {28'd0, irq_vec}, 32'd7);
    pend_clr = 12'h080;
    tick();
    pend_clr = '0;
    chk("wd drop irq", {31'd0, irq}, 32'd0);
    chk("wd drop pend", {20'd0, pending}, 32'd0);
    chk("wd vec hold", {28'd0, irq_vec}, 32'd7);
    tick();
    chk("wd gap irq", {31'd0, irq}, 32'd0);

    // last_grant is still 3, so round-robin picks 5 before 2.
    rr_mode = 1'b1;
    set_src(12'h024);
    tick();
    set_src('0);
    grant_cycle(4'd5, '0);
    grant_cycle(4'd2, '0);

    // Park last_grant at 11, then round-robin over 0, 5, 9.
    rr_mode = 1'b0;
    set_src(12'h800);
    tick();
    set_src('0);
    grant_cycle(4'd11, '0);
    rr_mode = 1'b1;
    set_src(12'h221);
    tick();
    set_src('0);
    grant_cycle(4'd0, 12'h001);
    grant_cycle(4'd5, 12'h020);
    grant_cycle(4'd9, 12'h200);
    grant_cycle(4'd0, 12'h001);
    rr_mode = 1'b0;
    grant_cycle(4'd0, 12'h001);
    grant_cycle(4'd0, 12'h001);
    pend_clr = 12'hFFF;
    tick();
    pend_clr = '0;
    chk("clr all pend", {20'd0, pending}, 32'd0);
    tick(); tick();
    chk("clr all irq", {31'd0, irq}, 32'd0);

    // Reset in the middle of a handshake, then a stale ack.
    set_src(12'h002);
    tick();
    set_src('0);
    tick();
    chk("pre-rst irq", {31'd0, irq}, 32'd1);
    chk("pre-rst vec", {28'd0, irq_vec}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst irq",  {31'd0, irq}, 32'd0);
    chk("rst pend", {20'd0, pending}, 32'd0);
    chk("rst ier",  {20'd0, ier}, 32'd0);
    chk("rst vec",  {28'd0, irq_vec}, 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("stale ack irq",  {31'd0, irq}, 32'd0);
    chk("stale ack pend", {20'd0, pending}, 32'd0);
    tick();
    chk("stale ack later", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
